// File: rtl/meta_info_pkg.sv
// -----------------------------------------------------------------------------
// meta_info_pkg
// Shared types and constants for the meta-info string sequencer.
//   state_t  : sequencer FSM states
//   IDX_W    : width of the ROM project and character indices
//   CHR_W    : width of one ROM character
//   CHR_NUL  : string terminator
//   CHR_NL   : newline appended after a string
//   sat_len  : clamps the 7-bit internal character count onto the 6-bit len port
// -----------------------------------------------------------------------------
package meta_info_pkg;

   localparam int IDX_W = 6;
   localparam int CHR_W = 8;

   localparam logic [CHR_W-1:0] CHR_NUL = 8'h00;
   localparam logic [CHR_W-1:0] CHR_NL  = 8'h0A;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WAIT = 3'd1,
      EMIT = 3'd2,
      NL   = 3'd3,
      DONE = 3'd4
   } state_t;

   // A 64-character string overflows the 6-bit len port; report 63 instead of wrapping to 0.
   function automatic logic [IDX_W-1:0] sat_len(input logic [IDX_W:0] cnt);
      logic [IDX_W-1:0] res;
      if (cnt[IDX_W]) begin
         res = 6'd63;
      end else begin
         res = cnt[IDX_W-1:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/meta_info_sequencer.sv
// -----------------------------------------------------------------------------
// meta_info_sequencer
// Streams one project's metadata string out of the meta-info character ROM onto
// a byte valid/ready port, optionally followed by a newline.
// Ports:
//   clock, reset          : rising-edge clock, asynchronous active-low reset
//   start, proj_sel       : request to stream the string of proj_sel (IDLE only)
//   busy, done, len       : status; done pulses once, len = characters emitted
//   rom_proj_idx,
//   rom_chr_idx, rom_chr  : ROM address lines (owned here) and returned data
//   out_data, out_valid,
//   out_ready             : byte stream towards the sink
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module meta_info_sequencer
   import meta_info_pkg::*;
#(
   parameter int ROM_LATENCY  = 2,
   parameter int MAX_LEN      = 63,
   parameter int EMIT_NEWLINE = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [IDX_W-1:0] proj_sel,
   output logic             busy,
   output logic             done,
   output logic [IDX_W-1:0] len,
   output logic [IDX_W-1:0] rom_proj_idx,
   output logic [IDX_W-1:0] rom_chr_idx,
   input  logic [CHR_W-1:0] rom_chr,
   output logic [CHR_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   // Wait reload leaves exactly ROM_LATENCY edges between an index change and the sampling edge.
   localparam logic [2:0]       WAIT_INIT = 3'(ROM_LATENCY - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = 6'(MAX_LEN - 1);
   localparam logic             ADD_NL    = (EMIT_NEWLINE != 0);

   state_t           state_q, state_d;
   logic [2:0]       wait_q, wait_d;
   logic [IDX_W:0]   count_q, count_d;
   logic [IDX_W-1:0] rom_proj_idx_q, rom_proj_idx_d;
   logic [IDX_W-1:0] rom_chr_idx_q, rom_chr_idx_d;
   logic [CHR_W-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic             done_q, done_d;
   logic [IDX_W-1:0] len_q, len_d;
   logic             busy_q, busy_d;
   logic             xfer_s;

   assign xfer_s = out_valid_q & out_ready;

   // Next-state and next-output computation for the whole sequencer.
   always_comb begin
      state_d        = state_q;
      wait_d         = wait_q;
      count_d        = count_q;
      rom_proj_idx_d = rom_proj_idx_q;
      rom_chr_idx_d  = rom_chr_idx_q;
      out_data_d     = out_data_q;
      out_valid_d    = out_valid_q;
      done_d         = 1'b0;
      len_d          = len_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               rom_proj_idx_d = proj_sel;
               rom_chr_idx_d  = 6'd0;
               count_d        = 7'd0;
               wait_d         = WAIT_INIT;
               state_d        = WAIT;
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (wait_q != 3'd0) begin
               wait_d = wait_q - 3'd1;
            end else if (rom_chr == CHR_NUL) begin
               if (ADD_NL) begin
                  out_data_d  = CHR_NL;
                  out_valid_d = 1'b1;
                  state_d     = NL;
               end else begin
                  done_d  = 1'b1;
                  len_d   = sat_len(count_q);
                  state_d = DONE;
               end
            end else begin
               out_data_d  = rom_chr;
               out_valid_d = 1'b1;
               state_d     = EMIT;
            end
         end
         EMIT: begin
            if (xfer_s) begin
               count_d = count_q + 7'd1;
               // The last allowed index ends the string; the index never wraps back to 0.
               if (rom_chr_idx_q == LAST_IDX) begin
                  if (ADD_NL) begin
                     out_data_d  = CHR_NL;
                     out_valid_d = 1'b1;
                     state_d     = NL;
                  end else begin
                     out_valid_d = 1'b0;
                     done_d      = 1'b1;
                     len_d       = sat_len(count_d);
                     state_d     = DONE;
                  end
               end else begin
                  rom_chr_idx_d = rom_chr_idx_q + 6'd1;
                  wait_d        = WAIT_INIT;
                  out_valid_d   = 1'b0;
                  state_d       = WAIT;
               end
            end else begin
               state_d = EMIT;
            end
         end
         NL: begin
            if (xfer_s) begin
               out_valid_d = 1'b0;
               done_d      = 1'b1;
               len_d       = sat_len(count_q);
               state_d     = DONE;
            end else begin
               state_d = NL;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q        <= IDLE;
         wait_q         <= 3'd0;
         count_q        <= 7'd0;
         rom_proj_idx_q <= 6'd0;
         rom_chr_idx_q  <= 6'd0;
         out_data_q     <= 8'h00;
         out_valid_q    <= 1'b0;
         done_q         <= 1'b0;
         len_q          <= 6'd0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         wait_q         <= wait_d;
         count_q        <= count_d;
         rom_proj_idx_q <= rom_proj_idx_d;
         rom_chr_idx_q  <= rom_chr_idx_d;
         out_data_q     <= out_data_d;
         out_valid_q    <= out_valid_d;
         done_q         <= done_d;
         len_q          <= len_d;
         busy_q         <= busy_d;
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign len          = len_q;
   assign rom_proj_idx = rom_proj_idx_q;
   assign rom_chr_idx  = rom_chr_idx_q;
   assign out_data     = out_data_q;
   assign out_valid    = out_valid_q;

endmodule

// File: tb/tb_meta_info_sequencer.sv
// -----------------------------------------------------------------------------
// tb_meta_info_sequencer
// Directed bench for meta_info_sequencer. Two instances: the default
// configuration (newline appended) and one with EMIT_NEWLINE=0. Each has its
// own ROM model: the index change at the start/transfer edge plus one
// registered read give the two-edge latency.
// ROM contents: proj 5 = "ABC", proj 0 = "", proj 9 = 63 x 'x' (no NUL).
// -----------------------------------------------------------------------------
module tb_meta_info_sequencer;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic [5:0] proj_sel = 6'd0;
   logic       out_ready = 1'b1;
   logic       busy, done, out_valid;
   logic [5:0] len, rom_proj_idx, rom_chr_idx;
   logic [7:0] out_data;
   logic [7:0] rom_chr = 8'h00;

   logic       start_nn = 1'b0;
   logic [5:0] proj_sel_nn = 6'd0;
   logic       busy_nn, done_nn, out_valid_nn;
   logic [5:0] len_nn, rom_proj_idx_nn, rom_chr_idx_nn;
   logic [7:0] out_data_nn;
   logic [7:0] rom_chr_nn = 8'h00;

   int         vectors = 0;
   int         miscompares = 0;
   logic [7:0] xfer_q[$];
   int         done_cnt = 0;
   int         xfer_nn = 0;
   int         max_idx;

   always #5 clock = ~clock;

   meta_info_sequencer u_dut (
      .clock(clock), .reset(reset), .start(start), .proj_sel(proj_sel),
      .busy(busy), .done(done), .len(len),
      .rom_proj_idx(rom_proj_idx), .rom_chr_idx(rom_chr_idx), .rom_chr(rom_chr),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
   );

   meta_info_sequencer #(.ROM_LATENCY(2), .MAX_LEN(63), .EMIT_NEWLINE(0)) u_dut_nn (
      .clock(clock), .reset(reset), .start(start_nn), .proj_sel(proj_sel_nn),
      .busy(busy_nn), .done(done_nn), .len(len_nn),
      .rom_proj_idx(rom_proj_idx_nn), .rom_chr_idx(rom_chr_idx_nn), .rom_chr(rom_chr_nn),
      .out_data(out_data_nn), .out_valid(out_valid_nn), .out_ready(1'b1)
   );

   function automatic logic [7:0] rom_lookup(input logic [5:0] p, input logic [5:0] c);
      logic [7:0] r;
      r = 8'h00;
      if (p == 6'd5) begin
         if (c == 6'd0) r = 8'h41;
         else if (c == 6'd1) r = 8'h42;
         else if (c == 6'd2) r = 8'h43;
         else r = 8'h00;
      end else if (p == 6'd9) begin
         if (c < 6'd63) r = 8'h78;
         else r = 8'h00;
      end else begin
         r = 8'h00;
      end
      return r;
   endfunction

   // Registered ROM reads for both instances.
   always @(posedge clock) begin
      rom_chr    <= rom_lookup(rom_proj_idx, rom_chr_idx);
      rom_chr_nn <= rom_lookup(rom_proj_idx_nn, rom_chr_idx_nn);
   end

   // Sink monitor: records every accepted byte and every done pulse.
   always @(posedge clock) begin
      if (reset === 1'b1) begin
         if (out_valid === 1'b1 && out_ready === 1'b1) xfer_q.push_back(out_data);
         if (done === 1'b1) done_cnt <= done_cnt + 1;
         if (out_valid_nn === 1'b1) xfer_nn <= xfer_nn + 1;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_stream(input logic [5:0] p);
      proj_sel = p;
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      max_idx = 0;
      while (busy === 1'b1 && n < 1000) begin
         tick();
         n++;
         if (int'(rom_chr_idx) > max_idx) max_idx = int'(rom_chr_idx);
      end
      chk({tag, "_timeout"}, 32'(n < 1000), 32'd1);
   endtask

   task automatic wait_b(input string tag);
      int n;
      n = 0;
      while (!(out_valid === 1'b1 && out_data === 8'h42) && n < 50) begin
         tick();
         n++;
      end
      chk({tag, "_reach_b"}, 32'(n < 50), 32'd1);
   endtask

   task automatic check_stream(input string tag, input int base, input string exp);
      int sz;
      sz = xfer_q.size() - base;
      chk({tag, "_count"}, 32'(sz), 32'(exp.len()));
      for (int i = 0; i < exp.len(); i++) begin
         if (i < sz) chk($sformatf("%s_byte%0d", tag, i), 32'(xfer_q[base + i]), 32'(exp[i]));
      end
   endtask

   initial begin
      int    base;
      int    dsnap;
      string long_s;

      // Reset held with start and out_ready active: nothing moves.
      reset = 1'b0; start = 1'b1; proj_sel = 6'd5; out_ready = 1'b1;
      repeat (3) tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_len", 32'(len), 32'd0);
      chk("rst_rom_proj", 32'(rom_proj_idx), 32'd0);
      chk("rst_rom_chr", 32'(rom_chr_idx), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_no_xfer", 32'(xfer_q.size()), 32'd0);
      start = 1'b0;
      reset = 1'b1;
      tick();

      // Nominal "ABC\n", first out_valid right after E2, proj_sel changes ignored.
      base = xfer_q.size(); dsnap = done_cnt;
      start_stream(6'd5);
      proj_sel = 6'd9;
      chk("nom_busy_e0", 32'(busy), 32'd1);
      chk("nom_rom_proj", 32'(rom_proj_idx), 32'd5);
      chk("nom_valid_e0", 32'(out_valid), 32'd0);
      tick();
      chk("nom_valid_e1", 32'(out_valid), 32'd0);
      tick();
      chk("nom_valid_e2", 32'(out_valid), 32'd1);
      chk("nom_data_e2", 32'(out_data), 32'h41);
      wait_idle("nom");
      check_stream("nom", base, "ABC\n");
      chk("nom_done_once", 32'(done_cnt - dsnap), 32'd1);
      chk("nom_len", 32'(len), 32'd3);
      chk("nom_busy_end", 32'(busy), 32'd0);

      // Backpressure during 'B'.
      base = xfer_q.size(); dsnap = done_cnt;
      start_stream(6'd5);
      wait_b("bp");
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_data", 32'(out_data), 32'h42);
         chk("bp_idx", 32'(rom_chr_idx), 32'd1);
         chk("bp_valid", 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      wait_idle("bp");
      check_stream("bp", base, "ABC\n");
      chk("bp_done_once", 32'(done_cnt - dsnap), 32'd1);

      // Empty string with newline.
      base = xfer_q.size(); dsnap = done_cnt;
      start_stream(6'd0);
      wait_idle("empty");
      check_stream("empty", base, "\n");
      chk("empty_len", 32'(len), 32'd0);
      chk("empty_done_once", 32'(done_cnt - dsnap), 32'd1);

      // Empty string without newline: done two cycles after start, no transfers.
      proj_sel_nn = 6'd0;
      start_nn    = 1'b1;
      tick();
      start_nn    = 1'b0;
      chk("nn_busy_e0", 32'(busy_nn), 32'd1);
      chk("nn_done_e0", 32'(done_nn), 32'd0);
      tick();
      chk("nn_done_e1", 32'(done_nn), 32'd0);
      tick();
      chk("nn_done_e2", 32'(done_nn), 32'd1);
      chk("nn_len", 32'(len_nn), 32'd0);
      tick();
      chk("nn_done_e3", 32'(done_nn), 32'd0);
      chk("nn_busy_e3", 32'(busy_nn), 32'd0);
      chk("nn_no_xfer", 32'(xfer_nn), 32'd0);

      // Maximum length: 63 x 'x' then newline; index peaks at 62.
      long_s = "";
      for (int i = 0; i < 63; i++) long_s = {long_s, "x"};
      long_s = {long_s, "\n"};
      base = xfer_q.size(); dsnap = done_cnt;
      start_stream(6'd9);
      wait_idle("max");
      check_stream("max", base, long_s);
      chk("max_peak_idx", 32'(max_idx), 32'd62);
      chk("max_len", 32'(len), 32'd63);
      chk("max_done_once", 32'(done_cnt - dsnap), 32'd1);

      // Start pulse while busy is ignored.
      base = xfer_q.size(); dsnap = done_cnt;
      start_stream(6'd5);
      wait_b("ign");
      proj_sel = 6'd0;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      chk("ign_rom_proj", 32'(rom_proj_idx), 32'd5);
      wait_idle("ign");
      check_stream("ign", base, "ABC\n");
      chk("ign_done_once", 32'(done_cnt - dsnap), 32'd1);
      repeat (4) tick();
      chk("ign_not_queued", 32'(busy), 32'd0);

      // Reset during EMIT of 'B': immediate return to reset values, no done.
      base = xfer_q.size(); dsnap = done_cnt;
      start_stream(6'd5);
      wait_b("abort");
      out_ready = 1'b0;
      tick();
      reset = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_valid", 32'(out_valid), 32'd0);
      chk("abort_data", 32'(out_data), 32'd0);
      chk("abort_idx", 32'(rom_chr_idx), 32'd0);
      chk("abort_proj", 32'(rom_proj_idx), 32'd0);
      chk("abort_len", 32'(len), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      repeat (2) tick();
      out_ready = 1'b1;
      reset = 1'b1;
      tick();
      chk("abort_no_done", 32'(done_cnt - dsnap), 32'd0);
      check_stream("abort_part", base, "A");

      // Clean stream after the abort.
      base = xfer_q.size(); dsnap = done_cnt;
      start_stream(6'd5);
      wait_idle("post");
      check_stream("post", base, "ABC\n");
      chk("post_len", 32'(len), 32'd3);
      chk("post_done_once", 32'(done_cnt - dsnap), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
